// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// Instruction fetch unit.
// Drives word-aligned read requests to instruction memory, captures the
// returned word into a one-entry holding register and presents it to the
// decoder with a valid/ready handshake. Branch/jump redirects replace the
// fetch pc and squash any word returned or held in the same cycle.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to trap redirects whose
// target is not word aligned. The unit then parks in a fault state with
// fetch_fault set until the next reset. Without the macro, misaligned
// targets are silently rounded down to the enclosing word and fetch_fault
// is tied low.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    // Instruction memory read port
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    // Control-flow redirect from execute
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    // Decoder handshake
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,

    output logic        fetch_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] inst_pc_q, inst_pc_d;

    // Word-aligned redirect target. Subtracting the low bits rounds down to
    // the enclosing word while keeping every bit of redirect_pc in use.
    logic [31:0] redirect_target;
    assign redirect_target = redirect_pc - {30'b0, redirect_pc[1:0]};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic redirect_misaligned;
    assign redirect_misaligned = |redirect_pc[1:0];
`endif

    // State, pc and holding registers; reset forces a clean idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            inst_pc_q <= inst_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky fault flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

    // Next-state logic. Redirect outranks both memory ack and decoder ready.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        inst_pc_d = inst_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_d   = fault_q;
`endif

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (redirect_misaligned) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = redirect_target;
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = redirect_target;
                    state_d = S_FETCH;
`endif
                end else if (imem_ack) begin
                    // Only place the read data is ever sampled.
                    instr_d   = imem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                    state_d   = S_HOLD;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // The held word is dropped: inst_valid falls with the
                    // state change, the stale contents are never presented.
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (redirect_misaligned) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = redirect_target;
                        state_d = S_FETCH;
                    end
`else
                    pc_d    = redirect_target;
                    state_d = S_FETCH;
`endif
                end else if (inst_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_FAULT: begin
                // Terminal until reset; redirects and acks are ignored.
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers, so nothing glitches in reset.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign inst_valid  = (state_q == S_HOLD);
    assign instruction = instr_q;
    assign inst_pc     = inst_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, word address of the current request (equals pc).
REQ-006 SHALL have port imem_ack, input, 1, memory has returned data this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, read data, valid only when imem_ack=1.
REQ-008 SHALL have port redirect_valid, input, 1, branch/jump taken; replace pc this cycle.
REQ-009 SHALL have port redirect_pc, input, 32, redirect target.
REQ-010 SHALL have port inst_valid, output, 1, instruction/inst_pc hold a valid fetched word for the decoder.
REQ-011 SHALL have port inst_ready, input, 1, decoder accepts the word this cycle.
REQ-012 SHALL have port instruction, output, 32, fetched instruction word for the decoder.
REQ-013 SHALL have port inst_pc, output, 32, address the instruction was fetched from.
REQ-014 SHALL have port fetch_fault, output, 1, misaligned-redirect fault flag.

Function
REQ-015 SHALL implement FSM states S_IDLE, S_FETCH, S_HOLD, S_FAULT, all registered.
REQ-016 S_IDLE SHALL last exactly one cycle after reset release, then go to S_FETCH; imem_req=0 and inst_valid=0 in S_IDLE.
REQ-017 imem_req SHALL be 1 exactly when state is S_FETCH; imem_addr SHALL always equal the pc register.
REQ-018 In S_FETCH with imem_ack=1 and redirect_valid=0: instruction<=imem_rdata, inst_pc<=pc, pc<=pc+4 (modulo 2^32), next state S_HOLD.
REQ-019 In S_FETCH with imem_ack=0 and redirect_valid=0: hold pc, remain S_FETCH.
REQ-020 inst_valid SHALL be 1 exactly when state is S_HOLD; instruction and inst_pc SHALL remain stable throughout S_HOLD.
REQ-021 In S_HOLD with inst_ready=1 and redirect_valid=0: next state S_FETCH (one word per two cycles minimum throughput).
REQ-022 redirect_valid=1 in S_FETCH or S_HOLD SHALL load pc<=redirect_pc, discard any data acked or held that cycle, and go to S_FETCH; redirect has priority over imem_ack and inst_ready.
REQ-023 redirect_valid SHALL be ignored in S_IDLE and S_FAULT.
REQ-024 pc wrap: 32'hFFFF_FFFC+4 SHALL yield 32'h0000_0000 with no flag.
REQ-025 imem_rdata SHALL never be sampled when imem_ack=0; imem_ack outside S_FETCH SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL immediately force state S_IDLE, pc=RESET_PC, instruction=32'h0000_0013 (NOP), inst_pc=RESET_PC, fetch_fault=0, hence imem_req=0, inst_valid=0.
REQ-027 Reset asserted mid-fetch or mid-hold SHALL abandon the transaction; no output glitches high during reset.

Configuration
REQ-028 Macro FETCH_MISALIGN_CHECK_EN defined: redirect_valid=1 with redirect_pc[1:0]!=0 in S_FETCH/S_HOLD SHALL move to S_FAULT, set fetch_fault=1 sticky until reset, imem_req=0, inst_valid=0, pc unchanged.
REQ-029 Macro FETCH_MISALIGN_CHECK_EN undefined: redirect SHALL load {redirect_pc[31:2],2'b00}, S_FAULT unreachable, fetch_fault tied 0.

Verification
REQ-030 Reset release, RESET_PC=0, ack next cycle with 32'h00500093 -> imem_addr=0, then inst_valid=1, instruction=32'h00500093, inst_pc=0, pc=4.
REQ-031 Hold inst_ready=0 for 5 cycles in S_HOLD -> inst_valid stays 1, instruction stable, imem_req=0; ready=1 -> next cycle imem_req=1, imem_addr=4.
REQ-032 Redirect to 32'h0000_0100 same cycle as imem_ack -> data discarded, inst_valid stays 0, next imem_addr=32'h100.
REQ-033 pc=32'hFFFF_FFFC, ack -> inst_pc=32'hFFFF_FFFC, next imem_addr=0.
REQ-034 Redirect to 32'h0000_0102: with macro -> fetch_fault=1, imem_req=0 until reset; without -> imem_addr=32'h100, fetch_fault=0.
REQ-035 rst_n pulsed low during S_HOLD -> inst_valid=0 and imem_req=0 immediately, fetch restarts at RESET_PC.
